// File: rtl/multi_cycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core.
// Walks each instruction through IF/ID/EX/MEM/WB and drives the datapath
// strobes for the current state. Owns the ECALL halt and a watchdog on
// memory waits. The optional performance counters are built only when
// the PERF_CNT_EN macro is defined.
module multi_cycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       is_halt,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       mem_error,
  output logic       illegal_inst
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  // The wait counter only ever holds completed wait cycles, so it tops out
  // at MEM_TIMEOUT-1: the cycle that would reach MEM_TIMEOUT is the one
  // that trips the error.
  localparam bit                 WDOG_EN   = (MEM_TIMEOUT > 0);
  localparam int unsigned        WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;
  logic              mem_waiting;

  // Next state, watchdog and per-state datapath strobes.
  // NOTE: every output is given a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    mem_waiting  = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = 2'd0;
    pc_source    = 2'd0;
    wb_sel       = 2'd0;
    illegal_inst = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read    = 1'b1;
        mem_waiting = !mem_ready;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end
      end

      // ALUOut <= PC + imm, used later as the branch/JAL target.
      S_ID: begin
        alu_src_b = 2'd1;
        case (opcode)
          OP_SYSTEM: begin
            if (is_halt) begin
              state_d = S_HALT;
            end else begin
              pc_write  = 1'b1;
              pc_source = 2'd1;
              state_d   = S_IF;
            end
          end
          OP_JAL: state_d = S_WB;
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR:
            state_d = S_EX;
          default: begin
            illegal_inst = 1'b1;
            pc_write     = 1'b1;
            pc_source    = 2'd1;
            state_d      = S_IF;
          end
        endcase
      end

      S_EX: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_ARITH: begin
            alu_op  = 2'd2;
            state_d = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_b = 2'd1;
            alu_op    = 2'd2;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 2'd1;
            state_d   = S_MEM;
          end
          OP_JALR: begin
            alu_src_b = 2'd1;
            state_d   = S_WB;
          end
          OP_BRANCH: begin
            alu_op    = 2'd1;
            pc_write  = 1'b1;
            pc_source = bcond ? 2'd0 : 2'd1;
            state_d   = S_IF;
          end
          // Unreachable while opcode is held stable; recover to fetch.
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        i_or_d      = 1'b1;
        mem_read    = (opcode == OP_LOAD);
        mem_write   = (opcode == OP_STORE);
        mem_waiting = !mem_ready;
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end else begin
            pc_write  = 1'b1;
            pc_source = 2'd1;
            state_d   = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = ((opcode == OP_JAL) || (opcode == OP_JALR)) ? 2'd0 : 2'd1;
        if (opcode == OP_LOAD) begin
          wb_sel = 2'd1;
        end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          wb_sel = 2'd2;
        end
        state_d = S_IF;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IF;
    endcase

    // Watchdog: a mem_ready in the timeout cycle clears mem_waiting, so it wins.
    wait_cnt_d  = '0;
    mem_error_d = mem_error_q;
    if (WDOG_EN && mem_waiting) begin
      if (wait_cnt_q == WAIT_LAST) begin
        mem_error_d = 1'b1;
        state_d     = S_HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end

    // While reset is held the core sits in fetch with no side effects.
    if (!reset) begin
      state_d      = S_IF;
      wait_cnt_d   = '0;
      mem_error_d  = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      mem_read     = 1'b1;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      alu_op       = 2'd0;
      pc_source    = 2'd0;
      wb_sel       = 2'd0;
      illegal_inst = 1'b0;
    end
  end

  // State, wait counter and sticky error registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IF;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign mem_error = mem_error_q;

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] retired_cnt_q, retired_cnt_d;

  // Counters advance only while running; both freeze once halted.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    if (state_q != S_HALT) begin
      cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
      if (pc_write) begin
        retired_cnt_d = retired_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_count   = cycle_cnt_q;
  assign retired_count = retired_cnt_q;
`else
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule
